// File: rtl/cuckoo_l1_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cuckoo_l1_loader
//  Description : Cuckoo-hash insert engine for a two-bank (T1/T2) L1 table.
//                Keeps a shadow copy of the table so it can find victims,
//                evicts up to MAX_KICKS times per insert, and flushes the
//                whole table on request.
//  Revision    : 1.0 - initial release
// ============================================================================
module cuckoo_l1_loader #(
    parameter int MAX_KICKS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ins_valid,
    output logic        ins_ready,
    input  logic [9:0]  ins_h1,
    input  logic [9:0]  ins_h2,
    input  logic [7:0]  ins_key,
    input  logic [8:0]  ins_data,
    input  logic        clr_start,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [8:0]  wr_data,
    output logic        busy,
    output logic        ins_done,
    output logic        ins_fail,
    output logic [8:0]  fail_data,
    output logic [7:0]  kick_cnt
);

    localparam logic [7:0]  MAX_K    = 8'(MAX_KICKS);
    localparam logic [10:0] LAST_ADR = 11'h7FF;

    // probe phase: first look in T1, then T2, then start kicking from T1
    localparam logic [1:0] PH_T1   = 2'd0;
    localparam logic [1:0] PH_T2   = 2'd1;
    localparam logic [1:0] PH_KICK = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HASH = 3'd1,
        S_RD   = 3'd2,
        S_CHK  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5,
        S_FAIL = 3'd6,
        S_CLR  = 3'd7
    } state_t;

    state_t      state;

    // latched request
    logic [9:0]  req_h1;
    logic [9:0]  req_h2;
    logic [7:0]  req_key;
    logic [8:0]  req_data;

    // home indices of the item being inserted
    logic [9:0]  a1;
    logic [9:0]  a2;

    // item currently looking for a slot
    logic        cur_bank;
    logic [9:0]  cur_idx;
    logic [9:0]  cur_alt;
    logic [8:0]  cur_data;
    logic [1:0]  phase;

    // shadow table: {valid, alt_idx[9:0], data[8:0]}
    logic [19:0] shadow_mem [0:2047];
    logic [19:0] sh_wdata;
    logic [19:0] rd_data;
    logic [10:0] rd_addr;

    function automatic logic [9:0] calc_idx(input logic [9:0] h, input logic [7:0] key);
        logic [9:0] sum;
        sum = {h[6:0], 3'b000} + {3'b000, h[9:3]} + {2'b00, key};
        return sum ^ h;
    endfunction

    assign rd_addr = {cur_bank, cur_idx};

    // Shadow table: written alongside every L1 write, read with 1-cycle latency
    always_ff @(posedge clk) begin
        if (wr_en) begin
            shadow_mem[wr_addr] <= sh_wdata;
        end
        rd_data <= shadow_mem[rd_addr];
    end

    // Insert / flush controller with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ins_ready <= 1'b1;
            busy      <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            sh_wdata  <= '0;
            ins_done  <= 1'b0;
            ins_fail  <= 1'b0;
            fail_data <= '0;
            kick_cnt  <= '0;
            req_h1    <= '0;
            req_h2    <= '0;
            req_key   <= '0;
            req_data  <= '0;
            a1        <= '0;
            a2        <= '0;
            cur_bank  <= 1'b0;
            cur_idx   <= '0;
            cur_alt   <= '0;
            cur_data  <= '0;
            phase     <= PH_T1;
        end else begin
            ins_done <= 1'b0;
            ins_fail <= 1'b0;
            wr_en    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clr_start) begin
                        // flush wins over a simultaneous insert
                        state     <= S_CLR;
                        ins_ready <= 1'b0;
                        busy      <= 1'b1;
                        wr_en     <= 1'b1;
                        wr_addr   <= '0;
                        wr_data   <= '0;
                        sh_wdata  <= '0;
                    end else if (ins_valid) begin
                        state     <= S_HASH;
                        ins_ready <= 1'b0;
                        busy      <= 1'b1;
                        req_h1    <= ins_h1;
                        req_h2    <= ins_h2;
                        req_key   <= ins_key;
                        req_data  <= ins_data;
                    end
                end
                S_HASH: begin
                    a1       <= calc_idx(req_h1, req_key);
                    a2       <= calc_idx(req_h2, req_key);
                    cur_bank <= 1'b0;
                    cur_idx  <= calc_idx(req_h1, req_key);
                    cur_alt  <= calc_idx(req_h2, req_key);
                    cur_data <= req_data;
                    kick_cnt <= '0;
                    phase    <= PH_T1;
                    state    <= S_RD;
                end
                S_RD: begin
                    state <= S_CHK;
                end
                S_CHK: begin
                    if (!rd_data[19]) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= {cur_bank, cur_idx};
                        wr_data  <= cur_data;
                        sh_wdata <= {1'b1, cur_alt, cur_data};
                        state    <= S_WR;
                    end else if (phase == PH_T1) begin
                        cur_bank <= 1'b1;
                        cur_idx  <= a2;
                        cur_alt  <= a1;
                        phase    <= PH_T2;
                        state    <= S_RD;
                    end else if (phase == PH_T2) begin
                        // both homes taken: re-read T1 at a1 so the first kick evicts there
                        cur_bank <= 1'b0;
                        cur_idx  <= a1;
                        cur_alt  <= a2;
                        phase    <= PH_KICK;
                        state    <= S_RD;
                    end else if (kick_cnt == MAX_K) begin
                        fail_data <= cur_data;
                        ins_fail  <= 1'b1;
                        state     <= S_FAIL;
                    end else begin
                        // evict: cur takes the slot, victim moves to its alternate bank
                        wr_en    <= 1'b1;
                        wr_addr  <= {cur_bank, cur_idx};
                        wr_data  <= cur_data;
                        sh_wdata <= {1'b1, cur_alt, cur_data};
                        cur_bank <= ~cur_bank;
                        cur_idx  <= rd_data[18:9];
                        cur_alt  <= cur_idx;
                        cur_data <= rd_data[8:0];
                        kick_cnt <= kick_cnt + 8'd1;
                        state    <= S_RD;
                    end
                end
                S_WR: begin
                    ins_done <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE, S_FAIL: begin
                    ins_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                S_CLR: begin
                    if (wr_addr == LAST_ADR) begin
                        ins_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= wr_addr + 11'd1;
                    end
                end
                default: begin
                    ins_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cuckoo_l1_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cuckoo_l1_loader
//  Description : Directed self-checking bench for cuckoo_l1_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cuckoo_l1_loader;

    logic        clk;
    logic        rst_n;
    logic        ins_valid;
    logic        ins_ready;
    logic [9:0]  ins_h1;
    logic [9:0]  ins_h2;
    logic [7:0]  ins_key;
    logic [8:0]  ins_data;
    logic        clr_start;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [8:0]  wr_data;
    logic        busy;
    logic        ins_done;
    logic        ins_fail;
    logic [8:0]  fail_data;
    logic [7:0]  kick_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cuckoo_l1_loader #(.MAX_KICKS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_h1    (ins_h1),
        .ins_h2    (ins_h2),
        .ins_key   (ins_key),
        .ins_data  (ins_data),
        .clr_start (clr_start),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .ins_done  (ins_done),
        .ins_fail  (ins_fail),
        .fail_data (fail_data),
        .kick_cnt  (kick_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flush, with ins_valid raised in the same cycle as clr_start.
    task automatic do_flush(input string tag);
        int nwr;
        int bad;
        int ndone;
        int cyc;
        nwr   = 0;
        bad   = 0;
        ndone = 0;
        @(negedge clk);
        clr_start = 1'b1;
        ins_valid = 1'b1;
        ins_h1    = 10'h000;
        ins_h2    = 10'h001;
        ins_key   = 8'h41;
        ins_data  = 9'h1EE;
        for (cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            clr_start = 1'b0;
            ins_valid = 1'b0;
            if (wr_en) begin
                if (wr_addr !== 11'(nwr) || wr_data !== 9'h000) bad++;
                nwr++;
            end
            if (ins_done || ins_fail) ndone++;
            if (ins_ready) break;
        end
        chk({tag, "_writes"}, 32'(nwr), 32'd2048);
        chk({tag, "_seq_zero"}, 32'(bad), 32'd0);
        chk({tag, "_no_pulse"}, 32'(ndone), 32'd0);
        chk({tag, "_ready"}, {31'd0, ins_ready}, 32'd1);
        @(negedge clk);
        chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    // One insert; records the write traffic and completion until done/fail.
    task automatic do_insert(input logic [9:0] h1, input logic [9:0] h2, input logic [7:0] key,
                             input logic [8:0] data, input int clr_at,
                             output int nwr, output logic [10:0] first_addr, output logic [8:0] first_data,
                             output logic [10:0] last_addr, output logic [8:0] last_data,
                             output logic got_done, output logic got_fail, output int cycles);
        nwr        = 0;
        first_addr = '0;
        first_data = '0;
        last_addr  = '0;
        last_data  = '0;
        got_done   = 1'b0;
        got_fail   = 1'b0;
        cycles     = 0;
        @(negedge clk);
        ins_valid = 1'b1;
        ins_h1    = h1;
        ins_h2    = h2;
        ins_key   = key;
        ins_data  = data;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            ins_valid = 1'b0;
            clr_start = (cyc == clr_at);
            if (wr_en) begin
                if (nwr == 0) begin
                    first_addr = wr_addr;
                    first_data = wr_data;
                end
                last_addr = wr_addr;
                last_data = wr_data;
                nwr++;
            end
            if (ins_done) got_done = 1'b1;
            if (ins_fail) got_fail = 1'b1;
            if (got_done || got_fail) begin
                cycles = cyc;
                break;
            end
        end
        clr_start = 1'b0;
        chk("ins_no_timeout", {31'd0, got_done | got_fail}, 32'd1);
    endtask

    int          nwr;
    int          cycles;
    int          npulse;
    logic [10:0] fa;
    logic [8:0]  fd;
    logic [10:0] la;
    logic [8:0]  ld;
    logic        gd;
    logic        gf;

    initial begin
        rst_n     = 1'b0;
        ins_valid = 1'b0;
        ins_h1    = '0;
        ins_h2    = '0;
        ins_key   = '0;
        ins_data  = '0;
        clr_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ins_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_pulses", {30'd0, ins_done, ins_fail}, 32'd0);
        chk("rst_outs", {4'd0, fail_data, kick_cnt, wr_data, 2'd0}, 32'd0);
        chk("rst_wr_addr", {21'd0, wr_addr}, 32'd0);
        rst_n = 1'b1;

        // flush with a colliding insert request; flush wins
        do_flush("flush1");

        // first insert lands in T1
        do_insert(10'h000, 10'h001, 8'h41, 9'h055, 0, nwr, fa, fd, la, ld, gd, gf, cycles);
        chk("ins1_addr", {21'd0, fa}, 32'h041);
        chk("ins1_data", {23'd0, fd}, 32'h055);
        chk("ins1_nwr", 32'(nwr), 32'd1);
        chk("ins1_done", {30'd0, gd, gf}, 32'd2);
        chk("ins1_kicks", {24'd0, kick_cnt}, 32'd0);
        chk("ins1_latency", 32'(cycles), 32'd5);

        // same hashes: T1 slot taken, falls to T2
        do_insert(10'h000, 10'h001, 8'h41, 9'h0AA, 0, nwr, fa, fd, la, ld, gd, gf, cycles);
        chk("ins2_addr", {21'd0, fa}, 32'h448);
        chk("ins2_data", {23'd0, fd}, 32'h0AA);
        chk("ins2_nwr", 32'(nwr), 32'd1);
        chk("ins2_done", {30'd0, gd, gf}, 32'd2);
        chk("ins2_kicks", {24'd0, kick_cnt}, 32'd0);
        chk("ins2_latency", 32'(cycles), 32'd7);

        // third: three items cycle through two slots until the kick limit
        do_insert(10'h000, 10'h001, 8'h41, 9'h133, 0, nwr, fa, fd, la, ld, gd, gf, cycles);
        chk("ins3_fail", {30'd0, gd, gf}, 32'd1);
        chk("ins3_kicks", {24'd0, kick_cnt}, 32'd16);
        chk("ins3_nwr", 32'(nwr), 32'd16);
        chk("ins3_first_addr", {21'd0, fa}, 32'h041);
        chk("ins3_first_data", {23'd0, fd}, 32'h133);
        chk("ins3_last_addr", {21'd0, la}, 32'h448);
        chk("ins3_last_data", {23'd0, ld}, 32'h133);
        chk("ins3_fail_data", {23'd0, fail_data}, 32'h055);

        // empty T1 slot at index 0x009
        do_insert(10'h001, 10'h3FF, 8'h00, 9'h012, 0, nwr, fa, fd, la, ld, gd, gf, cycles);
        chk("ins4_addr", {21'd0, fa}, 32'h009);
        chk("ins4_data", {23'd0, fd}, 32'h012);
        chk("ins4_done", {30'd0, gd, gf}, 32'd2);

        // reset in the middle of a kick
        @(negedge clk);
        ins_valid = 1'b1;
        ins_h1    = 10'h000;
        ins_h2    = 10'h001;
        ins_key   = 8'h41;
        ins_data  = 9'h1FF;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            ins_valid = 1'b0;
            if (wr_en) break;
        end
        chk("kick_seen", {31'd0, wr_en}, 32'd1);
        chk("kick_cnt_1", {24'd0, kick_cnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, ins_ready}, 32'd1);
        chk("midrst_busy_wr", {30'd0, busy, wr_en}, 32'd0);
        chk("midrst_outs", {7'd0, fail_data, kick_cnt, ins_done, ins_fail, 6'd0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        npulse = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (ins_done || ins_fail || wr_en) npulse++;
        end
        chk("midrst_no_pulse", 32'(npulse), 32'd0);
        chk("midrst_idle", {30'd0, ins_ready, busy}, 32'd2);

        // shadow survives reset: 0x009 still taken, goes to T2; clr_start while busy ignored
        do_insert(10'h001, 10'h3FF, 8'h00, 9'h0C3, 2, nwr, fa, fd, la, ld, gd, gf, cycles);
        chk("keep_addr", {21'd0, fa}, 32'h788);
        chk("keep_nwr", 32'(nwr), 32'd1);
        chk("keep_done", {30'd0, gd, gf}, 32'd2);
        @(negedge clk);
        chk("keep_idle", {30'd0, ins_ready, busy}, 32'd2);

        // flush clears the shadow: 0x009 is free again
        do_flush("flush2");
        do_insert(10'h001, 10'h3FF, 8'h00, 9'h021, 0, nwr, fa, fd, la, ld, gd, gf, cycles);
        chk("post_flush_addr", {21'd0, fa}, 32'h009);
        chk("post_flush_data", {23'd0, fd}, 32'h021);
        chk("post_flush_done", {30'd0, gd, gf}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cuckoo_l1_loader.md
CUCKOO_L1_LOADER -- requirements
Module: cuckoo_l1_loader

Interface
REQ-001 Parameter MAX_KICKS, default 16, SHALL set the eviction limit per insert; legal range 1..255.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 ins_valid  in  1  insert request valid.
REQ-005 ins_ready  out  1  loader can accept an insert.
REQ-006 ins_h1 / ins_h2  in  10 each  prehash values for T1 and T2.
REQ-007 ins_key  in  8  key byte.
REQ-008 ins_data  in  9  entry payload, the T3 port address.
REQ-009 clr_start  in  1  single-cycle pulse that starts a table flush.
REQ-010 wr_en  out  1  write strobe to the L1 table RAM write port.
REQ-011 wr_addr  out  11  {bank, index}: bank 0 = T1, bank 1 = T2.
REQ-012 wr_data  out  9  payload written.
REQ-013 busy  out  1  insert or flush in progress.
REQ-014 ins_done / ins_fail  out  1 each  one-cycle completion pulses.
REQ-015 fail_data  out  9  payload of the entry dropped on failure.
REQ-016 kick_cnt  out  8  evictions used by the last insert.

Function
REQ-017 Index SHALL be computed mod 2^10: idx = (({h[6:0],3'b000} + {3'b000,h[9:3]} + key) ^ h); a1 uses ins_h1, a2 uses ins_h2.
REQ-018 The block SHALL keep an internal shadow memory of 2048 x 20 bits, {valid, alt_idx[9:0], data[8:0]}, addressed like wr_addr, with a synchronous read of 1-cycle latency.
REQ-019 The FSM SHALL have states IDLE, HASH, RD, CHK, WR, DONE, FAIL and CLR; ins_ready SHALL be 1 only in IDLE.
REQ-020 IDLE -> HASH on ins_valid && ins_ready; the request fields SHALL be latched in that cycle.
REQ-021 HASH SHALL register a1 and a2, set cur = {bank0, a1, alt=a2, data}, clear kick_cnt and first_pass, and go to RD.
REQ-022 RD SHALL issue a shadow read at {cur_bank, cur_idx}; CHK SHALL evaluate the read result on the next cycle.
REQ-023 CHK, slot invalid -> WR: write the L1 RAM and the shadow with {1, cur_alt, cur_data}, then go to DONE.
REQ-024 CHK, slot valid, first probe of bank 0 -> retry at {bank1, a2, alt=a1} via RD; no write occurs.
REQ-025 CHK, slot valid otherwise -> kick:
  - write cur into the slot;
  - the victim becomes cur with bank = ~cur_bank, idx = victim.alt_idx, alt = old cur_idx;
  - kick_cnt increments;
  - go to RD.
REQ-026 The first kick SHALL evict from bank 0 at a1.
REQ-027 If kick_cnt reaches MAX_KICKS at CHK with the slot valid, the FSM SHALL go to FAIL without writing, and fail_data SHALL be cur_data, which is the pending item.
REQ-028 DONE and FAIL SHALL each last one cycle, pulse ins_done or ins_fail respectively, then return to IDLE.
REQ-029 wr_en SHALL be high exactly one cycle per table write, and the shadow SHALL be updated in that same cycle.
REQ-030 Duplicate keys SHALL NOT be detected; each insert occupies a new slot.
REQ-031 clr_start SHALL be honoured only in IDLE and SHALL take priority over a simultaneous ins_valid.
REQ-032 CLR SHALL write wr_data = 0 and shadow = 0 to addresses 0..2047, one per cycle (2048 cycles), then return to IDLE without a done pulse.
REQ-033 clr_start outside IDLE SHALL be ignored.
REQ-034 busy SHALL be 1 in every state except IDLE.

Reset
REQ-035 On rst_n low, at any time including mid-insert or mid-flush, the FSM SHALL go to IDLE and every output SHALL be 0 except ins_ready, which is 1.
REQ-036 Reset SHALL NOT clear the shadow contents; software SHALL issue clr_start after reset before the first insert.
REQ-037 The pending insert is lost on reset, and no done or fail pulse SHALL be produced for it.

Verification
REQ-038 Flush, then insert h1=0, h2=1, key=0x41, data=0x055 -> wr_addr=0x041, wr_data=0x055, ins_done, kick_cnt=0.
REQ-039 Repeat the same insert -> T1 slot occupied, so wr_addr = {1, idx(h2=1, key=0x41)} = 0x448, ins_done, kick_cnt=0.
REQ-040 Third identical insert -> kick: 0x041 is overwritten, its victim moves to bank 1 and collides, and inserts continue until ins_fail with kick_cnt=16 and a valid fail_data.
REQ-041 Pulse clr_start and ins_valid in the same cycle -> flush runs 2048 cycles with wr_data=0, then ins_ready=1 and no ins_done.
REQ-042 Assert rst_n low during a kick -> next cycle ins_ready=1, busy=0, wr_en=0, and no pulse.
REQ-043 Insert h1=1, key=0 -> T1 index 0x009.
